// File: rtl/ym3438_bus_master.sv
// ym3438_bus_master: host-side register-write initiator for the YM3438 CPU bus.
// Define YM3438_BUS_BUSY_POLL_EN to poll the busy bit before each data write (else fixed wait).
module ym3438_bus_master #(
    parameter int unsigned T_SETUP   = 1,
    parameter int unsigned T_PULSE   = 2,
    parameter int unsigned T_HOLD    = 1,
    parameter int unsigned T_RECOVER = 2,
    parameter int unsigned POLL_MAX  = 255,
    parameter int unsigned WAIT_FIX  = 32
) (
    input  logic       MCLK,
    input  logic       IC,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_bank,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic [1:0] ADDRESS,
    output logic [7:0] DATA_o,
    output logic       DATA_o_z,
    input  logic [7:0] DATA_i,
    input  logic       timeout_clr,
    output logic       busy_timeout,
    output logic       idle
);

    typedef enum logic [3:0] {
        StIdle, StASetup, StAStrobe, StAHold, StARec,
        StPSetup, StPStrobe, StPHold, StPRec, StWait,
        StDSetup, StDStrobe, StDHold, StDRec
    } state_e;

    state_e      r_state, w_state_d;
    logic [15:0] r_cnt, w_dur;
    logic        w_last;
    logic        w_accept;

    logic        r_bank, w_bank_d;
    logic [7:0]  r_addr, w_addr_d;
    logic [7:0]  r_data, w_data_d;

    logic        r_cs, w_cs_d;
    logic        r_wr, w_wr_d;
    logic        w_rd_d;
    logic [1:0]  r_address, w_address_d;
    logic [7:0]  r_dout, w_dout_d;
    logic        r_z, w_z_d;

`ifdef YM3438_BUS_BUSY_POLL_EN
    logic        r_rd;
    logic        r_busy;
    logic [7:0]  r_poll;
    logic        r_timeout;
    logic        w_timeout_set;
    logic        w_poll_inc;
`else
    logic        w_unused;
`endif

    assign req_ready = (r_state == StIdle) && IC;
    assign idle      = req_ready;
    assign w_accept  = (r_state == StIdle) && req_valid;

    // Fields for the transfer about to run; the live request only matters on acceptance.
    assign w_bank_d = w_accept ? req_bank : r_bank;
    assign w_addr_d = w_accept ? req_addr : r_addr;
    assign w_data_d = w_accept ? req_data : r_data;

    always_comb begin
        w_dur = 16'd1;
        case (r_state)
            StASetup, StPSetup, StDSetup:    w_dur = 16'(T_SETUP);
            StAStrobe, StPStrobe, StDStrobe: w_dur = 16'(T_PULSE);
            StAHold, StPHold, StDHold:       w_dur = 16'(T_HOLD);
            StARec, StPRec, StDRec:          w_dur = 16'(T_RECOVER);
            StWait:                          w_dur = 16'(WAIT_FIX);
            default:                         w_dur = 16'd1;
        endcase
    end

    assign w_last = (r_cnt == w_dur - 16'd1);

    always_comb begin
        w_state_d = r_state;
`ifdef YM3438_BUS_BUSY_POLL_EN
        w_timeout_set = 1'b0;
        w_poll_inc    = 1'b0;
`endif
        case (r_state)
            StIdle:    if (req_valid) w_state_d = StASetup;
            StASetup:  if (w_last) w_state_d = StAStrobe;
            StAStrobe: if (w_last) w_state_d = StAHold;
            StAHold:   if (w_last) w_state_d = StARec;
            StARec: begin
                if (w_last) begin
`ifdef YM3438_BUS_BUSY_POLL_EN
                    w_state_d = StPSetup;
`else
                    w_state_d = StWait;
`endif
                end
            end
`ifdef YM3438_BUS_BUSY_POLL_EN
            StPSetup:  if (w_last) w_state_d = StPStrobe;
            StPStrobe: if (w_last) w_state_d = StPHold;
            StPHold:   if (w_last) w_state_d = StPRec;
            StPRec: begin
                if (w_last) begin
                    if (!r_busy) begin
                        w_state_d = StDSetup;
                    end else if (r_poll == 8'(POLL_MAX - 1)) begin
                        // Give up waiting but still issue the write.
                        w_state_d     = StDSetup;
                        w_timeout_set = 1'b1;
                    end else begin
                        w_state_d  = StPSetup;
                        w_poll_inc = 1'b1;
                    end
                end
            end
`else
            StWait:    if (w_last) w_state_d = StDSetup;
`endif
            StDSetup:  if (w_last) w_state_d = StDStrobe;
            StDStrobe: if (w_last) w_state_d = StDHold;
            StDHold:   if (w_last) w_state_d = StDRec;
            StDRec:    if (w_last) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with r_state.
    always_comb begin
        w_cs_d      = 1'b1;
        w_wr_d      = 1'b1;
        w_rd_d      = 1'b1;
        w_address_d = r_address;
        w_dout_d    = r_dout;
        w_z_d       = 1'b1;
        case (w_state_d)
            StASetup, StAStrobe, StAHold: begin
                w_cs_d      = 1'b0;
                w_wr_d      = (w_state_d != StAStrobe);
                w_address_d = {w_bank_d, 1'b0};
                w_dout_d    = w_addr_d;
                w_z_d       = 1'b0;
            end
            StPSetup, StPStrobe, StPHold: begin
                w_cs_d      = 1'b0;
                w_rd_d      = (w_state_d != StPStrobe);
                w_address_d = 2'b00;
            end
            StDSetup, StDStrobe, StDHold: begin
                w_cs_d      = 1'b0;
                w_wr_d      = (w_state_d != StDStrobe);
                w_address_d = {w_bank_d, 1'b1};
                w_dout_d    = w_data_d;
                w_z_d       = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            r_state   <= StIdle;
            r_cnt     <= 16'd0;
            r_bank    <= 1'b0;
            r_addr    <= 8'h00;
            r_data    <= 8'h00;
            r_cs      <= 1'b1;
            r_wr      <= 1'b1;
            r_address <= 2'b00;
            r_dout    <= 8'h00;
            r_z       <= 1'b1;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= (w_state_d != r_state) ? 16'd0 : r_cnt + 16'd1;
            r_bank    <= w_bank_d;
            r_addr    <= w_addr_d;
            r_data    <= w_data_d;
            r_cs      <= w_cs_d;
            r_wr      <= w_wr_d;
            r_address <= w_address_d;
            r_dout    <= w_dout_d;
            r_z       <= w_z_d;
        end
    end

`ifdef YM3438_BUS_BUSY_POLL_EN
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            r_rd      <= 1'b1;
            r_busy    <= 1'b0;
            r_poll    <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_rd <= w_rd_d;
            if (r_state == StPStrobe && w_last) r_busy <= DATA_i[7];
            if (r_state == StARec) r_poll <= 8'd0;
            else if (w_poll_inc)   r_poll <= r_poll + 8'd1;
            if (w_timeout_set)    r_timeout <= 1'b1;
            else if (timeout_clr) r_timeout <= 1'b0;
        end
    end

    assign RD           = r_rd;
    assign busy_timeout = r_timeout;
`else
    assign RD           = 1'b1;
    assign busy_timeout = 1'b0;
    assign w_unused     = ^{DATA_i, timeout_clr, w_rd_d};
`endif

    assign CS       = r_cs;
    assign WR       = r_wr;
    assign ADDRESS  = r_address;
    assign DATA_o   = r_dout;
    assign DATA_o_z = r_z;

endmodule

// File: tb/tb_ym3438_bus_master.sv
// Bench for ym3438_bus_master: a bus monitor turns CS-low windows into access records, which are
// compared against the access list a request should produce.
module tb_ym3438_bus_master;

    localparam int TS = 1;
    localparam int TP = 2;
    localparam int TH = 1;
    localparam int TR = 2;
    localparam int PM = 255;
    localparam int WF = 32;
`ifdef YM3438_BUS_BUSY_POLL_EN
    localparam bit POLL_EN = 1'b1;
`else
    localparam bit POLL_EN = 1'b0;
`endif

    logic       MCLK, IC;
    logic       req_valid, req_ready, req_bank;
    logic [7:0] req_addr, req_data;
    logic       CS, WR, RD;
    logic [1:0] ADDRESS;
    logic [7:0] DATA_o;
    logic       DATA_o_z;
    logic [7:0] data_i;
    logic       timeout_clr, busy_timeout, idle;

    ym3438_bus_master #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_RECOVER(TR), .POLL_MAX(PM), .WAIT_FIX(WF)
    ) dut (
        .MCLK(MCLK), .IC(IC), .req_valid(req_valid), .req_ready(req_ready), .req_bank(req_bank),
        .req_addr(req_addr), .req_data(req_data), .CS(CS), .WR(WR), .RD(RD), .ADDRESS(ADDRESS),
        .DATA_o(DATA_o), .DATA_o_z(DATA_o_z), .DATA_i(data_i), .timeout_clr(timeout_clr),
        .busy_timeout(busy_timeout), .idle(idle)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    typedef struct {
        bit         is_rd;
        logic [1:0] addr;
        logic [7:0] data;
        int         cs_len;
        int         setup_len;
        int         strobe_len;
        int         zlo;
        int         gap;
    } acc_t;

    typedef struct {
        bit         bank;
        logic [7:0] a;
        logic [7:0] d;
        int         busy;
        logic [1:0] exp_aa;
        logic [1:0] exp_da;
    } vec_t;

    acc_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         rd_total = 0;
    int         rd_base = 0;
    int         busy_n = 0;
    int         both_low = 0;
    logic [7:0] noise = 8'h00;

    // Chip model: the first busy_n status reads of a request report busy.
    assign data_i = ((rd_total - rd_base) < busy_n) ? (noise | 8'h80) : (noise & 8'h7F);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bus monitor
    initial begin
        acc_t cur;
        bit   in_acc;
        bit   prev_rd;
        int   gap;
        in_acc  = 1'b0;
        prev_rd = 1'b1;
        gap     = 0;
        cur     = '{default: 0};
        forever begin
            @(negedge MCLK);
            if (!IC) begin
                in_acc  = 1'b0;
                prev_rd = 1'b1;
                gap     = 0;
            end else begin
                if (!WR && !RD) both_low++;
                if (RD && !prev_rd) rd_total++;
                prev_rd = RD;
                if (!CS) begin
                    if (!in_acc) begin
                        in_acc  = 1'b1;
                        cur     = '{default: 0};
                        cur.gap = gap;
                        gap     = 0;
                    end
                    cur.cs_len++;
                    if (!DATA_o_z) cur.zlo++;
                    if (!WR || !RD) begin
                        cur.strobe_len++;
                        cur.is_rd = !RD;
                        cur.addr  = ADDRESS;
                        cur.data  = DATA_o;
                    end else if (cur.strobe_len == 0) begin
                        cur.setup_len++;
                    end
                end else begin
                    if (in_acc) begin
                        q.push_back(cur);
                        in_acc = 1'b0;
                    end
                    gap++;
                end
            end
        end
    end

    function automatic int exp_polls(input int busy);
        if (!POLL_EN) return 0;
        return (busy < PM) ? busy + 1 : PM;
    endfunction

    task automatic send(input bit b, input logic [7:0] a, input logic [7:0] d, input int busy);
        int n;
        @(negedge MCLK);
        busy_n    = busy;
        rd_base   = rd_total;
        noise     = 8'($urandom_range(0, 255));
        req_bank  = b;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge MCLK);
            n++;
        end
        chk("accept", int'(req_ready), 1);
        @(negedge MCLK);
        req_valid = 1'b0;
        // Fields must already be captured.
        req_bank  = ~b;
        req_addr  = ~a;
        req_data  = ~d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!idle && n < 5000) begin
            @(negedge MCLK);
            n++;
        end
        chk("idle_return", int'(idle), 1);
    endtask

    task automatic check_txn(input logic [7:0] a, input logic [7:0] d, input int busy,
                             input logic [1:0] exp_aa, input logic [1:0] exp_da);
        int np;
        np = exp_polls(busy);
        chk("access_count", q.size(), np + 2);
        if (q.size() == np + 2) begin
            for (int i = 0; i < np + 2; i++) begin
                bit         e_rd;
                logic [1:0] e_a;
                e_rd = (i > 0) && (i < np + 1);
                e_a  = (i == 0) ? exp_aa : (e_rd ? 2'b00 : exp_da);
                chk($sformatf("kind[%0d]", i), int'(q[i].is_rd), int'(e_rd));
                chk($sformatf("address[%0d]", i), int'(q[i].addr), int'(e_a));
                if (!e_rd) chk($sformatf("data[%0d]", i), int'(q[i].data), int'((i == 0) ? a : d));
                chk($sformatf("cs_low[%0d]", i), q[i].cs_len, TS + TP + TH);
                chk($sformatf("setup[%0d]", i), q[i].setup_len, TS);
                chk($sformatf("strobe[%0d]", i), q[i].strobe_len, TP);
                chk($sformatf("drive[%0d]", i), q[i].zlo, e_rd ? 0 : TS + TP + TH);
                if (i > 0)
                    chk($sformatf("gap[%0d]", i), q[i].gap,
                        (i == np + 1 && !POLL_EN) ? TR + WF : TR);
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int   n;
        IC          = 1'b0;
        req_valid   = 1'b0;
        req_bank    = 1'b0;
        req_addr    = 8'h00;
        req_data    = 8'h00;
        timeout_clr = 1'b0;

        vecs.push_back('{bank: 0, a: 8'h28, d: 8'hF0, busy: 0,    exp_aa: 2'b00, exp_da: 2'b01});
        vecs.push_back('{bank: 1, a: 8'hB4, d: 8'hC0, busy: 0,    exp_aa: 2'b10, exp_da: 2'b11});
        vecs.push_back('{bank: 0, a: 8'h30, d: 8'h71, busy: 3,    exp_aa: 2'b00, exp_da: 2'b01});
        vecs.push_back('{bank: 1, a: 8'h40, d: 8'h7F, busy: 254,  exp_aa: 2'b10, exp_da: 2'b11});
        vecs.push_back('{bank: 0, a: 8'hA0, d: 8'h55, busy: 1000, exp_aa: 2'b00, exp_da: 2'b01});
        for (int i = 0; i < 6; i++) begin
            v.bank   = 1'($urandom_range(0, 1));
            v.a      = 8'($urandom_range(0, 255));
            v.d      = 8'($urandom_range(0, 255));
            v.busy   = int'($urandom_range(0, 4));
            v.exp_aa = {v.bank, 1'b0};
            v.exp_da = {v.bank, 1'b1};
            vecs.push_back(v);
        end

        // Reset state
        repeat (3) @(negedge MCLK);
        chk("rst_cs", int'(CS), 1);
        chk("rst_wr", int'(WR), 1);
        chk("rst_rd", int'(RD), 1);
        chk("rst_address", int'(ADDRESS), 0);
        chk("rst_data", int'(DATA_o), 0);
        chk("rst_z", int'(DATA_o_z), 1);
        chk("rst_timeout", int'(busy_timeout), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_idle", int'(idle), 0);
        IC = 1'b1;
        @(negedge MCLK);
        chk("post_rst_ready", int'(req_ready), 1);
        chk("post_rst_idle", int'(idle), 1);
        q.delete();

        foreach (vecs[k]) begin
            q.delete();
            send(vecs[k].bank, vecs[k].a, vecs[k].d, vecs[k].busy);
            wait_idle();
            check_txn(vecs[k].a, vecs[k].d, vecs[k].busy, vecs[k].exp_aa, vecs[k].exp_da);
            chk("busy_timeout", int'(busy_timeout), int'(POLL_EN && vecs[k].busy >= PM));
            timeout_clr = 1'b1;
            @(negedge MCLK);
            timeout_clr = 1'b0;
            chk("timeout_clr", int'(busy_timeout), 0);
        end

        // Back-to-back: second request held valid while the first runs.
        q.delete();
        @(negedge MCLK);
        busy_n    = 0;
        rd_base   = rd_total;
        req_bank  = 1'b0;
        req_addr  = 8'h11;
        req_data  = 8'h22;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge MCLK); n++; end
        @(negedge MCLK);
        req_bank = 1'b1;
        req_addr = 8'h33;
        req_data = 8'h44;
        n = 0;
        while (!req_ready && n < 5000) begin @(negedge MCLK); n++; end
        chk("b2b_accept", int'(req_ready), 1);
        @(negedge MCLK);
        req_valid = 1'b0;
        wait_idle();
        n = exp_polls(0) + 2;
        chk("b2b_count", q.size(), 2 * n);
        if (q.size() == 2 * n) begin
            chk("b2b_gap", q[n].gap, TR + 1);
            chk("b2b_addr", int'(q[n].addr), 2);
            chk("b2b_data", int'(q[n].data), 8'h33);
            chk("b2b_last_data", int'(q[2 * n - 1].data), 8'h44);
        end

        // Reset in the middle of the address strobe.
        send(1'b1, 8'h5A, 8'hA5, 0);
        n = 0;
        while (WR && n < 20) begin @(negedge MCLK); n++; end
        chk("mid_wr_seen", int'(WR), 0);
        IC        = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("mid_cs", int'(CS), 1);
        chk("mid_wr", int'(WR), 1);
        chk("mid_rd", int'(RD), 1);
        chk("mid_z", int'(DATA_o_z), 1);
        chk("mid_ready", int'(req_ready), 0);
        repeat (2) @(negedge MCLK);
        IC = 1'b1;
        @(negedge MCLK);
        chk("mid_post_ready", int'(req_ready), 1);
        q.delete();
        send(1'b0, 8'h2B, 8'h80, 1);
        wait_idle();
        check_txn(8'h2B, 8'h80, 1, 2'b00, 2'b01);

        chk("wr_rd_overlap", both_low, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
